// File: rtl/retire_multi_if.sv
// -----------------------------------------------------------------------------
// retire_multi_if
// Bundle between the ROB head window and the N-wide commit stage.
//   master : ROB / consumer side (drives head-slot info and flush, reads commit)
//   slave  : retire_multi (reads head-slot info, drives commit information)
// Head-slot fields are packed per slot with slot 0 in the least significant
// field. Commit outputs use the same per-slot packing.
// -----------------------------------------------------------------------------
interface retire_multi_if #(
   parameter int RETIRE_WIDTH = 4,
   parameter int ROB_WIDTH    = 5,
   parameter int ARCH_W       = 5,
   parameter int PHY_W        = 6,
   parameter int SQ_W         = 4,
   parameter int ADDR_WIDTH   = 32
);
   localparam int CNT_W = $clog2(RETIRE_WIDTH + 1);

   logic                             flush_i;
   logic [ROB_WIDTH-1:0]             rob_head_i;
   logic [RETIRE_WIDTH-1:0]          slot_finish_i;
   logic [3*RETIRE_WIDTH-1:0]        slot_kind_i;
   logic [ARCH_W*RETIRE_WIDTH-1:0]   slot_rd_arch_i;
   logic [PHY_W*RETIRE_WIDTH-1:0]    slot_rd_phy_old_i;
   logic [PHY_W*RETIRE_WIDTH-1:0]    slot_rd_phy_new_i;
   logic [SQ_W*RETIRE_WIDTH-1:0]     slot_store_id_i;
   logic [ADDR_WIDTH*RETIRE_WIDTH-1:0] slot_pc_i;
   logic [RETIRE_WIDTH-1:0]          slot_taken_i;
   logic [ADDR_WIDTH*RETIRE_WIDTH-1:0] slot_target_i;
   logic [RETIRE_WIDTH-1:0]          slot_mispredict_i;

   logic [CNT_W-1:0]                 retire_cnt_o;
   logic [RETIRE_WIDTH-1:0]          pr_valid_o;
   logic [ARCH_W*RETIRE_WIDTH-1:0]   rd_arch_o;
   logic [PHY_W*RETIRE_WIDTH-1:0]    rd_phy_old_o;
   logic [PHY_W*RETIRE_WIDTH-1:0]    rd_phy_new_o;
   logic [RETIRE_WIDTH-1:0]          store_valid_o;
   logic [SQ_W*RETIRE_WIDTH-1:0]     store_id_o;
   logic                             btb_valid_o;
   logic [ADDR_WIDTH-1:0]            btb_pc_o;
   logic [ADDR_WIDTH-1:0]            btb_target_o;
   logic                             btb_taken_o;
   logic                             redirect_o;
   logic [ADDR_WIDTH-1:0]            redirect_pc_o;
   logic                             done_o;
   logic [1:0]                       state_o;

   modport master (
      output flush_i, rob_head_i, slot_finish_i, slot_kind_i, slot_rd_arch_i,
             slot_rd_phy_old_i, slot_rd_phy_new_i, slot_store_id_i, slot_pc_i,
             slot_taken_i, slot_target_i, slot_mispredict_i,
      input  retire_cnt_o, pr_valid_o, rd_arch_o, rd_phy_old_o, rd_phy_new_o,
             store_valid_o, store_id_o, btb_valid_o, btb_pc_o, btb_target_o,
             btb_taken_o, redirect_o, redirect_pc_o, done_o, state_o
   );

   modport slave (
      input  flush_i, rob_head_i, slot_finish_i, slot_kind_i, slot_rd_arch_i,
             slot_rd_phy_old_i, slot_rd_phy_new_i, slot_store_id_i, slot_pc_i,
             slot_taken_i, slot_target_i, slot_mispredict_i,
      output retire_cnt_o, pr_valid_o, rd_arch_o, rd_phy_old_o, rd_phy_new_o,
             store_valid_o, store_id_o, btb_valid_o, btb_pc_o, btb_target_o,
             btb_taken_o, redirect_o, redirect_pc_o, done_o, state_o
   );
endinterface

// File: rtl/retire_multi.sv
// -----------------------------------------------------------------------------
// retire_multi
// N-wide in-order commit stage. Each cycle it looks at the RETIRE_WIDTH oldest
// ROB entries and retires the longest eligible in-order prefix, reporting the
// count combinationally to the ROB and registering the commit information for
// rename/free-list, store queue, BTB and front-end redirect.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : retire_multi_if.slave (head-slot inputs, flush, commit outputs)
// FSM: RUN (retiring), FLUSH (post-mispredict drain), HALT (after SYSTEM).
// -----------------------------------------------------------------------------
module retire_multi #(
   parameter int RETIRE_WIDTH = 4,
   parameter int ROB_WIDTH    = 5,
   parameter int ARCH_W       = 5,
   parameter int PHY_W        = 6,
   parameter int SQ_W         = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int MAX_STORES   = 1,
   parameter int FLUSH_LAT    = 2
) (
   input logic           clk,
   input logic           rst_n,
   retire_multi_if.slave bus
);
   localparam int CNT_W = $clog2(RETIRE_WIDTH + 1);
   localparam int FCW   = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;
   localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_LAT - 1);

   localparam logic [2:0] K_ALU    = 3'd1;
   localparam logic [2:0] K_LOAD   = 3'd2;
   localparam logic [2:0] K_STORE  = 3'd3;
   localparam logic [2:0] K_BRANCH = 3'd4;
   localparam logic [2:0] K_JUMP   = 3'd5;
   localparam logic [2:0] K_SYSTEM = 3'd6;

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HALT = 2'd2} state_t;

   state_t                         state;
   logic [FCW-1:0]                 flush_cnt;

   logic [CNT_W-1:0]               retire_cnt;
   logic [RETIRE_WIDTH-1:0]        pr_nxt;
   logic [RETIRE_WIDTH-1:0]        st_nxt;
   logic [ARCH_W*RETIRE_WIDTH-1:0] rd_arch_nxt;
   logic [PHY_W*RETIRE_WIDTH-1:0]  old_nxt;
   logic [PHY_W*RETIRE_WIDTH-1:0]  new_nxt;
   logic [SQ_W*RETIRE_WIDTH-1:0]   sid_nxt;
   logic                           br_ret;
   logic                           br_mis;
   logic                           br_taken;
   logic [ADDR_WIDTH-1:0]          br_pc;
   logic [ADDR_WIDTH-1:0]          br_target;
   logic                           sys_ret;

   logic                           blocked;
   logic [2:0]                     kind;
   logic                           is_st;
   logic                           is_br;
   int                             stores;
   int                             branches;

   // The ROB handles index wrap, so the head index is not needed here.
   logic unused_head;
   assign unused_head = ^bus.rob_head_i;

   // Walk the head window oldest-first. Once a slot fails to retire, or a
   // retiring slot is a mispredicted branch/jump or a SYSTEM op, everything
   // younger is blocked. Store and branch counts are cumulative over the prefix
   // so a slot that would exceed a per-cycle port limit ends the prefix.
   always_comb begin
      retire_cnt  = '0;
      pr_nxt      = '0;
      st_nxt      = '0;
      rd_arch_nxt = '0;
      old_nxt     = '0;
      new_nxt     = '0;
      sid_nxt     = '0;
      br_ret      = 1'b0;
      br_mis      = 1'b0;
      br_taken    = 1'b0;
      br_pc       = '0;
      br_target   = '0;
      sys_ret     = 1'b0;
      kind        = 3'd0;
      is_st       = 1'b0;
      is_br       = 1'b0;
      stores      = 0;
      branches    = 0;
      blocked     = (state != RUN) || bus.flush_i;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         kind  = bus.slot_kind_i[3*i +: 3];
         is_st = (kind == K_STORE);
         is_br = (kind == K_BRANCH) || (kind == K_JUMP);
         if (!blocked && bus.slot_finish_i[i] &&
             ((stores + int'(is_st)) <= MAX_STORES) &&
             ((branches + int'(is_br)) <= 1)) begin
            retire_cnt = retire_cnt + 1'b1;
            stores     = stores + int'(is_st);
            branches   = branches + int'(is_br);
            rd_arch_nxt[ARCH_W*i +: ARCH_W] = bus.slot_rd_arch_i[ARCH_W*i +: ARCH_W];
            old_nxt[PHY_W*i +: PHY_W]       = bus.slot_rd_phy_old_i[PHY_W*i +: PHY_W];
            new_nxt[PHY_W*i +: PHY_W]       = bus.slot_rd_phy_new_i[PHY_W*i +: PHY_W];
            // A jump only updates the mapping when it links to a real register.
            pr_nxt[i] = (kind == K_ALU) || (kind == K_LOAD) ||
                        ((kind == K_JUMP) && (bus.slot_rd_arch_i[ARCH_W*i +: ARCH_W] != '0));
            st_nxt[i] = is_st;
            if (is_st) begin
               sid_nxt[SQ_W*i +: SQ_W] = bus.slot_store_id_i[SQ_W*i +: SQ_W];
            end
            if (is_br) begin
               br_ret    = 1'b1;
               br_mis    = bus.slot_mispredict_i[i];
               br_taken  = bus.slot_taken_i[i];
               br_pc     = bus.slot_pc_i[ADDR_WIDTH*i +: ADDR_WIDTH];
               br_target = bus.slot_target_i[ADDR_WIDTH*i +: ADDR_WIDTH];
            end
            if (kind == K_SYSTEM) begin
               sys_ret = 1'b1;
            end
            if ((is_br && bus.slot_mispredict_i[i]) || (kind == K_SYSTEM)) begin
               blocked = 1'b1;
            end
         end else begin
            blocked = 1'b1;
         end
      end
   end

   assign bus.retire_cnt_o = retire_cnt;
   assign bus.state_o      = state;

   // Commit registers and the RUN/FLUSH/HALT FSM. An external flush wins over
   // mispredict/halt transitions but never leaves HALT; done_o is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= RUN;
         flush_cnt         <= '0;
         bus.pr_valid_o    <= '0;
         bus.rd_arch_o     <= '0;
         bus.rd_phy_old_o  <= '0;
         bus.rd_phy_new_o  <= '0;
         bus.store_valid_o <= '0;
         bus.store_id_o    <= '0;
         bus.btb_valid_o   <= 1'b0;
         bus.btb_pc_o      <= '0;
         bus.btb_target_o  <= '0;
         bus.btb_taken_o   <= 1'b0;
         bus.redirect_o    <= 1'b0;
         bus.redirect_pc_o <= '0;
         bus.done_o        <= 1'b0;
      end else begin
         bus.pr_valid_o    <= pr_nxt;
         bus.rd_arch_o     <= rd_arch_nxt;
         bus.rd_phy_old_o  <= old_nxt;
         bus.rd_phy_new_o  <= new_nxt;
         bus.store_valid_o <= st_nxt;
         bus.store_id_o    <= sid_nxt;
         bus.btb_valid_o   <= br_ret;
         bus.btb_pc_o      <= br_pc;
         bus.btb_target_o  <= br_target;
         bus.btb_taken_o   <= br_taken;
         bus.redirect_o    <= br_ret && br_mis;
         bus.redirect_pc_o <= (br_ret && br_mis) ? br_target : '0;
         if (bus.flush_i) begin
            if (state != HALT) begin
               state     <= RUN;
               flush_cnt <= '0;
            end
         end else begin
            case (state)
               RUN: begin
                  if (br_ret && br_mis) begin
                     state     <= FLUSH;
                     flush_cnt <= FLUSH_LOAD;
                  end else if (sys_ret) begin
                     state      <= HALT;
                     bus.done_o <= 1'b1;
                  end
               end
               FLUSH: begin
                  if (flush_cnt == '0) begin
                     state <= RUN;
                  end else begin
                     flush_cnt <= flush_cnt - 1'b1;
                  end
               end
               HALT: state <= HALT;
               default: state <= RUN;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_retire_multi.sv
// -----------------------------------------------------------------------------
// tb_retire_multi
// Directed bench for retire_multi (RETIRE_WIDTH=4, MAX_STORES=1, FLUSH_LAT=2):
// a table of single-cycle retire vectors plus hand sequences for mispredict
// flush, SYSTEM halt, external flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_retire_multi;
   localparam int RW = 4;
   localparam logic [2:0] K_OTH = 3'd0, K_ALU = 3'd1, K_LD = 3'd2, K_ST = 3'd3,
                          K_BR = 3'd4, K_JMP = 3'd5, K_SYS = 3'd6;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   retire_multi_if #(.RETIRE_WIDTH(RW)) bus ();

   retire_multi #(.RETIRE_WIDTH(RW), .MAX_STORES(1), .FLUSH_LAT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  finish;
      logic [11:0] kind;
      logic [19:0] rd_arch;
      logic [2:0]  exp_cnt;
      logic [3:0]  exp_pr;
      logic [3:0]  exp_st;
      logic        exp_btb;
      logic        chk_phy;
   } vec_t;

   localparam logic [19:0] ARCH_DEF = {5'd4, 5'd3, 5'd2, 5'd1};
   localparam logic [23:0] PHY_OLD  = {6'd6, 6'd5, 6'd4, 6'd3};

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic [3:0] finish, input logic [11:0] kind,
                                input logic [19:0] rd_arch, input logic [3:0] mis);
      bus.slot_finish_i     = finish;
      bus.slot_kind_i       = kind;
      bus.slot_rd_arch_i    = rd_arch;
      bus.slot_mispredict_i = mis;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t vecs [8];

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      bus.flush_i           = 1'b0;
      bus.rob_head_i        = 5'd7;
      bus.slot_rd_phy_old_i = PHY_OLD;
      bus.slot_rd_phy_new_i = {6'd40, 6'd41, 6'd42, 6'd43};
      bus.slot_store_id_i   = {4'd9, 4'd8, 4'd7, 4'd6};
      bus.slot_pc_i         = {32'h10C, 32'h108, 32'h104, 32'h100};
      bus.slot_taken_i      = 4'b1111;
      bus.slot_target_i     = {32'h400, 32'h300, 32'h200, 32'h180};
      applyStimulus(4'b0000, '0, ARCH_DEF, 4'b0000);

      vecs[0] = '{4'b1111, {K_ALU, K_ALU, K_ALU, K_ALU}, ARCH_DEF, 3'd4, 4'b1111, 4'b0000, 1'b0, 1'b1};
      vecs[1] = '{4'b1111, {K_ALU, K_ALU, K_ST,  K_ST }, ARCH_DEF, 3'd1, 4'b0000, 4'b0001, 1'b0, 1'b0};
      vecs[2] = '{4'b1110, {K_ALU, K_ALU, K_ALU, K_ALU}, ARCH_DEF, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vecs[3] = '{4'b1111, {K_ST,  K_ALU, K_ST,  K_ALU}, ARCH_DEF, 3'd3, 4'b0101, 4'b0010, 1'b0, 1'b0};
      vecs[4] = '{4'b1111, {K_ALU, K_ALU, K_JMP, K_BR }, ARCH_DEF, 3'd1, 4'b0000, 4'b0000, 1'b1, 1'b0};
      vecs[5] = '{4'b1111, {K_OTH, K_ALU, K_JMP, K_LD }, {5'd4, 5'd3, 5'd0, 5'd1}, 3'd4, 4'b0101, 4'b0000, 1'b1, 1'b0};
      vecs[6] = '{4'b1011, {K_ALU, K_ALU, K_ALU, K_ALU}, ARCH_DEF, 3'd2, 4'b0011, 4'b0000, 1'b0, 1'b0};
      vecs[7] = '{4'b1111, {K_ALU, K_ALU, K_ALU, K_JMP}, ARCH_DEF, 3'd4, 4'b1111, 4'b0000, 1'b1, 1'b0};

      // Reset state
      #12;
      checkOutput("reset_state", 64'(bus.state_o), 64'd0);
      checkOutput("reset_pr_valid", 64'(bus.pr_valid_o), 64'd0);
      checkOutput("reset_done", 64'(bus.done_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors: combinational count, then registered commit one edge later
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].finish, vecs[v].kind, vecs[v].rd_arch, 4'b0000);
         #1;
         checkOutput($sformatf("vec%0d_cnt", v), 64'(bus.retire_cnt_o), 64'(vecs[v].exp_cnt));
         step();
         checkOutput($sformatf("vec%0d_pr_valid", v), 64'(bus.pr_valid_o), 64'(vecs[v].exp_pr));
         checkOutput($sformatf("vec%0d_store_valid", v), 64'(bus.store_valid_o), 64'(vecs[v].exp_st));
         checkOutput($sformatf("vec%0d_btb_valid", v), 64'(bus.btb_valid_o), 64'(vecs[v].exp_btb));
         if (vecs[v].chk_phy)
            checkOutput($sformatf("vec%0d_phy_old", v), 64'(bus.rd_phy_old_o), 64'(PHY_OLD));
      end
      checkOutput("store_id_slot0", 64'(bus.store_id_o), 64'd0);

      // Mispredict on slot1 (target 0x200), then two FLUSH cycles, then RUN
      applyStimulus(4'b1111, {K_ALU, K_ALU, K_BR, K_ALU}, ARCH_DEF, 4'b0010);
      #1;
      checkOutput("mis_cnt", 64'(bus.retire_cnt_o), 64'd2);
      step();
      checkOutput("mis_redirect", 64'(bus.redirect_o), 64'd1);
      checkOutput("mis_redirect_pc", 64'(bus.redirect_pc_o), 64'h200);
      checkOutput("mis_state", 64'(bus.state_o), 64'd1);
      checkOutput("mis_pr_valid", 64'(bus.pr_valid_o), 64'b0001);
      checkOutput("mis_btb_pc", 64'(bus.btb_pc_o), 64'h104);
      checkOutput("mis_btb_target", 64'(bus.btb_target_o), 64'h200);
      checkOutput("mis_btb_taken", 64'(bus.btb_taken_o), 64'd1);
      applyStimulus(4'b1111, {K_ALU, K_ALU, K_ALU, K_ALU}, ARCH_DEF, 4'b0000);
      #1;
      checkOutput("flush1_cnt", 64'(bus.retire_cnt_o), 64'd0);
      step();
      checkOutput("flush2_redirect", 64'(bus.redirect_o), 64'd0);
      checkOutput("flush2_state", 64'(bus.state_o), 64'd1);
      checkOutput("flush2_cnt", 64'(bus.retire_cnt_o), 64'd0);
      checkOutput("flush2_pr_valid", 64'(bus.pr_valid_o), 64'd0);
      step();
      checkOutput("flush_done_state", 64'(bus.state_o), 64'd0);
      checkOutput("flush_done_cnt", 64'(bus.retire_cnt_o), 64'd4);
      step();

      // External flush with four finished ALU slots
      bus.flush_i = 1'b1;
      #1;
      checkOutput("xflush_cnt", 64'(bus.retire_cnt_o), 64'd0);
      step();
      checkOutput("xflush_pr_valid", 64'(bus.pr_valid_o), 64'd0);
      bus.flush_i = 1'b0;

      // External flush while in FLUSH returns to RUN
      applyStimulus(4'b1111, {K_ALU, K_ALU, K_BR, K_ALU}, ARCH_DEF, 4'b0010);
      step();
      checkOutput("mis2_state", 64'(bus.state_o), 64'd1);
      bus.flush_i = 1'b1;
      step();
      checkOutput("xflush_from_flush_state", 64'(bus.state_o), 64'd0);
      checkOutput("xflush_from_flush_redirect", 64'(bus.redirect_o), 64'd0);
      bus.flush_i = 1'b0;

      // Reset asserted mid-FLUSH clears everything immediately
      step();
      checkOutput("mis3_redirect", 64'(bus.redirect_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_flush_state", 64'(bus.state_o), 64'd0);
      checkOutput("rst_flush_redirect", 64'(bus.redirect_o), 64'd0);
      checkOutput("rst_flush_pr_valid", 64'(bus.pr_valid_o), 64'd0);
      checkOutput("rst_flush_btb_valid", 64'(bus.btb_valid_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // SYSTEM in slot2 halts; HALT survives flush_i, cleared by reset
      applyStimulus(4'b1111, {K_ALU, K_SYS, K_ALU, K_ALU}, ARCH_DEF, 4'b0000);
      #1;
      checkOutput("sys_cnt", 64'(bus.retire_cnt_o), 64'd3);
      step();
      checkOutput("sys_done", 64'(bus.done_o), 64'd1);
      checkOutput("sys_state", 64'(bus.state_o), 64'd2);
      checkOutput("sys_pr_valid", 64'(bus.pr_valid_o), 64'b0011);
      applyStimulus(4'b1111, {K_ALU, K_ALU, K_ALU, K_ALU}, ARCH_DEF, 4'b0000);
      #1;
      checkOutput("halt_cnt", 64'(bus.retire_cnt_o), 64'd0);
      bus.flush_i = 1'b1;
      step();
      checkOutput("halt_flush_state", 64'(bus.state_o), 64'd2);
      checkOutput("halt_flush_done", 64'(bus.done_o), 64'd1);
      bus.flush_i = 1'b0;
      step();
      checkOutput("halt_cnt2", 64'(bus.retire_cnt_o), 64'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("halt_rst_state", 64'(bus.state_o), 64'd0);
      checkOutput("halt_rst_done", 64'(bus.done_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_cnt", 64'(bus.retire_cnt_o), 64'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
